// File: rtl/io_pkg.sv
// Shared definitions for the IO block's run-length compressor and decompressor:
// field widths, compressor state encoding and the {run, value} word pack/unpack helpers.
package io_pkg;

    localparam int IO_DATA_W = 16;
    localparam int IO_RUN_W  = 16;
    localparam int IO_CNT_W  = 32;

    typedef enum logic [2:0] {
        IDLE,
        FIRST,
        RUN,
        FLUSH,
        DRAIN
    } io_cmp_state_t;

    function automatic logic [IO_RUN_W+IO_DATA_W-1:0] pack_word(
        input logic [IO_RUN_W-1:0]  run,
        input logic [IO_DATA_W-1:0] value
    );
        return {run, value};
    endfunction

    function automatic logic [IO_RUN_W-1:0] word_run(input logic [IO_RUN_W+IO_DATA_W-1:0] word);
        return word[IO_RUN_W+IO_DATA_W-1:IO_DATA_W];
    endfunction

    function automatic logic [IO_DATA_W-1:0] word_value(input logic [IO_RUN_W+IO_DATA_W-1:0] word);
        return word[IO_DATA_W-1:0];
    endfunction

endpackage

// File: rtl/io_sample_counter.sv
// Loadable down counter tracking how many samples of a transfer remain.
// The count holds at zero instead of wrapping.
module io_sample_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             zero
);

    assign zero = (count == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && !zero) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/io_rle_compressor.sv
// Run-length encodes a counted stream of samples into {run, value} words for the CPU bus.
// A single output register holds the pending word; input stalls while it cannot be freed.
module io_rle_compressor
    import io_pkg::*;
#(
    parameter int DATA_W = IO_DATA_W,
    parameter int RUN_W  = IO_RUN_W,
    parameter int CNT_W  = IO_CNT_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [CNT_W-1:0]       total_samples,
    input  logic                   in_valid,
    input  logic [DATA_W-1:0]      in_data,
    output logic                   in_ready,
    output logic                   out_valid,
    output logic [RUN_W+DATA_W-1:0] out_data,
    input  logic                   out_ready,
    output logic                   busy,
    output logic                   finished,
    output logic [CNT_W-1:0]       words_out
);

    localparam logic [RUN_W-1:0] RUN_MAX = '1;
    localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    io_cmp_state_t state, state_nxt;

    logic [DATA_W-1:0]       cur, cur_nxt;
    logic [RUN_W-1:0]        run, run_nxt;
    logic                    vld_p1;
    logic [RUN_W+DATA_W-1:0] word_p1, word_nxt;
    logic                    load_word;
    logic                    fin_nxt;
    logic                    cnt_load, cnt_dec, cnt_zero;
    logic [CNT_W-1:0]        remaining;
    logic                    words_clr;

    logic out_free, out_hs, accept, last_sample, same_run;

    io_sample_counter #(
        .CNT_W(CNT_W)
    ) u_remaining (
        .clk     (clk),
        .rst     (rst),
        .load    (cnt_load),
        .load_val(total_samples),
        .dec     (cnt_dec),
        .count   (remaining),
        .zero    (cnt_zero)
    );

    assign out_free    = !vld_p1 || out_ready;
    assign out_hs      = vld_p1 && out_ready;
    assign in_ready    = ((state == FIRST) || (state == RUN)) && out_free && !cnt_zero;
    assign accept      = in_valid && in_ready;
    assign last_sample = (remaining == CNT_W'(1));
    assign same_run    = (in_data == cur) && (run != RUN_MAX);

    assign out_valid = vld_p1;
    assign out_data  = word_p1;
    assign busy      = (state != IDLE);

    always_comb begin
        state_nxt = state;
        cur_nxt   = cur;
        run_nxt   = run;
        load_word = 1'b0;
        word_nxt  = word_p1;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        words_clr = 1'b0;
        fin_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (total_samples != '0) begin
                        cnt_load  = 1'b1;
                        words_clr = 1'b1;
                        cur_nxt   = '0;
                        run_nxt   = '0;
                        state_nxt = FIRST;
                    end else begin
                        fin_nxt = 1'b1;
                    end
                end
            end
            FIRST: begin
                if (accept) begin
                    cnt_dec = 1'b1;
                    cur_nxt = in_data;
                    run_nxt = RUN_ONE;
                    if (last_sample) begin
                        load_word = 1'b1;
                        word_nxt  = {RUN_ONE, in_data};
                        state_nxt = DRAIN;
                    end else begin
                        state_nxt = RUN;
                    end
                end
            end
            RUN: begin
                if (accept) begin
                    cnt_dec = 1'b1;
                    if (same_run) begin
                        run_nxt = run + 1'b1;
                        // A final sample that extends the run goes straight out, skipping FLUSH.
                        if (last_sample) begin
                            load_word = 1'b1;
                            word_nxt  = {run + 1'b1, cur};
                            state_nxt = DRAIN;
                        end
                    end else begin
                        load_word = 1'b1;
                        word_nxt  = {run, cur};
                        cur_nxt   = in_data;
                        run_nxt   = RUN_ONE;
                        if (last_sample) begin
                            state_nxt = FLUSH;
                        end
                    end
                end
            end
            FLUSH: begin
                if (out_free) begin
                    load_word = 1'b1;
                    word_nxt  = {run, cur};
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (out_hs) begin
                    fin_nxt   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cur       <= '0;
            run       <= '0;
            finished  <= 1'b0;
            words_out <= '0;
        end else begin
            state    <= state_nxt;
            cur      <= cur_nxt;
            run      <= run_nxt;
            finished <= fin_nxt;
            if (words_clr) begin
                words_out <= '0;
            end else if (out_hs) begin
                words_out <= sat_inc(words_out);
            end
        end
    end

    // Output register stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            word_p1 <= '0;
        end else if (load_word) begin
            vld_p1  <= 1'b1;
            word_p1 <= word_nxt;
        end else if (out_hs) begin
            vld_p1  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_io_rle_compressor.sv
// Self-checking bench for io_rle_compressor: table vectors, corner sequences and
// randomized transfers compared against a queue-based run-length model.
module tb_io_rle_compressor;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] total_samples;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;
    logic        busy;
    logic        finished;
    logic [31:0] words_out;

    io_rle_compressor dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .total_samples(total_samples),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_ready    (out_ready),
        .busy         (busy),
        .finished     (finished),
        .words_out    (words_out)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [15:0] smp[$];
    logic [31:0] exp_q[$];
    logic [31:0] got[$];

    typedef struct {
        int              n;
        logic [0:7][15:0] s;
        int              nw;
        logic [0:3][31:0] w;
    } vec_t;

    vec_t vt[6];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference: group equal consecutive samples, splitting any run at 65535.
    function automatic void model(input int n);
        int r;
        logic [15:0] v;
        exp_q.delete();
        r = 0;
        v = '0;
        for (int i = 0; i < n; i++) begin
            if (r != 0 && smp[i] == v && r < 65535) begin
                r++;
            end else begin
                if (r != 0) exp_q.push_back({r[15:0], v});
                v = smp[i];
                r = 1;
            end
        end
        if (r != 0) exp_q.push_back({r[15:0], v});
    endfunction

    // rmode: 0 ready always, 1 random ready, 2 ready low for 10 cycles mid-stream
    task automatic run_transfer(input string nm, input int n, input int rmode, input bit gaps);
        int idx, cyc, last_hs, fin_cyc, stab_bad, rdy_bad, busy_bad, busy_seen, vld_seen;
        bit fin_seen, prev_stall;
        logic [31:0] prev_word;
        got.delete();
        idx = 0; cyc = 0; last_hs = -10; fin_cyc = -1; fin_seen = 0;
        stab_bad = 0; rdy_bad = 0; busy_bad = 0; busy_seen = 0; vld_seen = 0;
        prev_stall = 0; prev_word = '0;
        @(negedge clk);
        start = 1'b1;
        total_samples = n;
        in_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        while (!fin_seen && cyc < n * 4 + 200) begin
            case (rmode)
                0: out_ready = 1'b1;
                1: out_ready = 1'($urandom_range(0, 1));
                default: out_ready = !(cyc >= 5 && cyc < 15);
            endcase
            if (idx < n && (!gaps || $urandom_range(0, 3) != 0)) begin
                in_valid = 1'b1;
                in_data  = smp[idx];
            end else begin
                in_valid = 1'b0;
                in_data  = 16'($urandom);
            end
            #1;
            if (prev_stall && out_data !== prev_word) stab_bad++;
            if (out_valid && !out_ready && in_ready) rdy_bad++;
            if (busy) busy_seen++;
            if (out_valid) vld_seen++;
            if (finished) begin
                fin_seen = 1;
                fin_cyc  = cyc;
                if (busy) busy_bad++;
            end
            if (out_valid && out_ready) begin
                got.push_back(out_data);
                last_hs = cyc;
            end
            if (in_valid && in_ready) idx++;
            prev_stall = out_valid && !out_ready;
            prev_word  = out_data;
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        chk({nm, ".finished_seen"}, fin_seen, 1);
        chk({nm, ".busy_at_finished"}, busy_bad, 0);
        chk({nm, ".data_stable_stalled"}, stab_bad, 0);
        chk({nm, ".in_ready_while_full"}, rdy_bad, 0);
        if (n == 0) begin
            chk({nm, ".finished_latency"}, fin_cyc, 0);
            chk({nm, ".busy_never"}, busy_seen, 0);
            chk({nm, ".valid_never"}, vld_seen, 0);
        end else begin
            chk({nm, ".finished_latency"}, fin_cyc, last_hs + 1);
            chk({nm, ".words_out"}, words_out, exp_q.size());
        end
        chk({nm, ".word_count"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            chk($sformatf("%s.word%0d", nm, i), got[i], exp_q[i]);
    endtask

    task automatic load_vec(input int k);
        smp.delete();
        exp_q.delete();
        for (int i = 0; i < vt[k].n; i++) smp.push_back(vt[k].s[i]);
        for (int i = 0; i < vt[k].nw; i++) exp_q.push_back(vt[k].w[i]);
    endtask

    initial begin
        vt[0] = '{n: 4, s: {16'd5, 16'd5, 16'd5, 16'd5, 16'd0, 16'd0, 16'd0, 16'd0},
                  nw: 1, w: {32'h0004_0005, 32'h0, 32'h0, 32'h0}};
        vt[1] = '{n: 5, s: {16'd1, 16'd2, 16'd2, 16'd3, 16'd3, 16'd0, 16'd0, 16'd0},
                  nw: 3, w: {32'h0001_0001, 32'h0002_0002, 32'h0002_0003, 32'h0}};
        vt[2] = '{n: 1, s: {16'd7, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0},
                  nw: 1, w: {32'h0001_0007, 32'h0, 32'h0, 32'h0}};
        vt[3] = '{n: 3, s: {16'd9, 16'd9, 16'd4, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0},
                  nw: 2, w: {32'h0002_0009, 32'h0001_0004, 32'h0, 32'h0}};
        vt[4] = '{n: 8, s: {16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'hFFFF},
                  nw: 2, w: {32'h0007_0000, 32'h0001_FFFF, 32'h0, 32'h0}};
        vt[5] = '{n: 4, s: {16'hA, 16'hB, 16'hA, 16'hB, 16'd0, 16'd0, 16'd0, 16'd0},
                  nw: 4, w: {32'h0001_000A, 32'h0001_000B, 32'h0001_000A, 32'h0001_000B}};

        rst = 1'b1; start = 1'b0; total_samples = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        #23;
        chk("reset.out_valid", out_valid, 0);
        chk("reset.out_data", out_data, 0);
        chk("reset.in_ready", in_ready, 0);
        chk("reset.busy", busy, 0);
        chk("reset.finished", finished, 0);
        chk("reset.words_out", words_out, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < 6; k++) begin
            load_vec(k);
            run_transfer($sformatf("vec%0d", k), vt[k].n, k % 2, k % 2);
        end

        smp.delete();
        exp_q.delete();
        run_transfer("zero_len", 0, 0, 0);

        smp.delete();
        for (int i = 0; i < 24; i++) smp.push_back(16'(i / 3));
        model(24);
        run_transfer("stall", 24, 2, 0);

        // Reset while a word sits stalled in the output register.
        @(negedge clk);
        start = 1'b1; total_samples = 10;
        @(negedge clk);
        start = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < 10 && !out_valid; i++) begin
            in_valid = 1'b1;
            in_data  = 16'(i % 2 + 1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("rst_mid.pre_valid", out_valid, 1);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid.out_valid", out_valid, 0);
        chk("rst_mid.out_data", out_data, 0);
        chk("rst_mid.busy", busy, 0);
        chk("rst_mid.in_ready", in_ready, 0);
        chk("rst_mid.words_out", words_out, 0);
        @(negedge clk);
        rst = 1'b0;
        begin
            int fin_cnt;
            fin_cnt = 0;
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                if (finished) fin_cnt++;
            end
            chk("rst_mid.no_finished", fin_cnt, 0);
        end
        load_vec(1);
        run_transfer("after_rst", vt[1].n, 0, 0);

        for (int t = 0; t < 20; t++) begin
            int n;
            n = $urandom_range(1, 40);
            smp.delete();
            for (int i = 0; i < n; i++)
                smp.push_back(($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 2)));
            model(n);
            run_transfer($sformatf("rand%0d", t), n, 1, 1);
        end

        smp.delete();
        for (int i = 0; i < 65537; i++) smp.push_back(16'h00AA);
        exp_q.delete();
        exp_q.push_back(32'hFFFF_00AA);
        exp_q.push_back(32'h0002_00AA);
        run_transfer("long_run", 65537, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
